// File: rtl/mem_if_pkg.sv
`default_nettype none
// ============================================================================
// mem_if_pkg : memory-port encodings, address-map defaults and FSM state type
// Rev 1.0
// ============================================================================
package mem_if_pkg;

  localparam logic [1:0] SIZE_1W  = 2'b00;
  localparam logic [1:0] SIZE_4W  = 2'b01;
  localparam logic [1:0] SIZE_8W  = 2'b10;
  localparam logic [1:0] SIZE_16W = 2'b11;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam logic [31:0] START_ADDR_DEFAULT = 32'h8002_0000;
  localparam int unsigned MEM_BYTES_DEFAULT  = 32'd1048576;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic logic [4:0] beats(input logic [1:0] size);
    logic [4:0] n;
    case (size)
      SIZE_1W:  n = 5'd1;
      SIZE_4W:  n = 5'd4;
      SIZE_8W:  n = 5'd8;
      SIZE_16W: n = 5'd16;
      default:  n = 5'd1;
    endcase
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_beat_counter.sv
`default_nettype none
// ============================================================================
// mem_beat_counter : remaining-beat counter, loaded with N, counts down per beat
// Rev 1.0
// ============================================================================
module mem_beat_counter (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       load,
  input  logic [4:0] load_count,
  input  logic       dec,
  output logic       last,
  output logic       zero
);

  logic [4:0] r_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= 5'd0;
    end else if (load) begin
      r_count <= load_count;
    end else if (dec && (r_count != 5'd0)) begin
      r_count <= r_count - 5'd1;
    end
  end

  assign last = (r_count == 5'd1);
  assign zero = (r_count == 5'd0);

endmodule
`default_nettype wire

// File: rtl/mem_burst_initiator.sv
`default_nettype none
// ============================================================================
// mem_burst_initiator : requester-side burst controller for the main-memory port
// Rev 1.0
// ============================================================================
module mem_burst_initiator
  import mem_if_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 32,
  parameter logic [ADDR_W-1:0] START_ADDR = START_ADDR_DEFAULT,
  parameter int unsigned       MEM_BYTES  = MEM_BYTES_DEFAULT
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic [DATA_W-1:0] wdata,
  output logic              wdata_pop,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_last,
  output logic              req_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic [1:0]        mem_access_size,
  output logic              mem_rw,
  output logic              mem_enable,
  input  logic              mem_busy,
  input  logic [DATA_W-1:0] mem_data_out
);

  // one extra bit so the end-of-burst sum can never wrap
  localparam logic [ADDR_W:0] c_mem_top =
    {1'b0, START_ADDR} + (ADDR_W+1)'(MEM_BYTES) - (ADDR_W+1)'(1);

  state_t            r_state;
  state_t            w_next_state;
  logic              w_ready;
  logic              w_enable;
  logic              w_take;
  logic              w_bad;
  logic              w_accept;
  logic              w_last;
  logic              w_zero;
  logic [ADDR_W:0]   w_last_byte;
  logic [ADDR_W-1:0] r_addr;
  logic              r_rw;
  logic [1:0]        r_size;
  logic              r_rd_beat;
  logic              r_rd_final;
  logic              r_pop;
  logic              r_err;
  logic              r_resp_valid;
  logic              r_resp_last;
  logic [DATA_W-1:0] r_resp_data;

  assign w_last_byte = {1'b0, req_addr} + (ADDR_W+1)'({beats(req_size), 2'b00})
                       - (ADDR_W+1)'(1);
  assign w_bad    = (req_addr[1:0] != 2'b00) || (req_addr < START_ADDR)
                    || (w_last_byte > c_mem_top);
  assign w_take   = req_valid && w_ready;
  assign w_accept = w_enable && !mem_busy;

  mem_beat_counter u_beat_counter (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (w_take && !w_bad),
    .load_count (beats(req_size)),
    .dec        (w_accept),
    .last       (w_last),
    .zero       (w_zero)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_take && !w_bad) w_next_state = ST_ISSUE;
      ST_ISSUE: begin
        if (w_zero) begin
          w_next_state = ST_IDLE;
        end else if (w_accept && w_last) begin
          w_next_state = (r_rw == RW_READ) ? ST_DRAIN : ST_IDLE;
        end
      end
      ST_DRAIN: w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_ready  = 1'b0;
    w_enable = 1'b0;
    case (r_state)
      ST_IDLE:  w_ready  = 1'b1;
      ST_ISSUE: w_enable = !w_zero;
      default:  ;
    endcase
  end

  // read data arrives one cycle after acceptance, so the capture strobe trails it
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_addr       <= '0;
      r_rw         <= 1'b0;
      r_size       <= 2'b00;
      r_rd_beat    <= 1'b0;
      r_rd_final   <= 1'b0;
      r_pop        <= 1'b0;
      r_err        <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_last  <= 1'b0;
      r_resp_data  <= '0;
    end else begin
      r_err        <= w_take && w_bad;
      r_rd_beat    <= w_accept && (r_rw == RW_READ);
      r_rd_final   <= w_accept && w_last && (r_rw == RW_READ);
      r_pop        <= w_accept && (r_rw == RW_WRITE);
      r_resp_valid <= r_rd_beat;
      r_resp_last  <= r_rd_final;
      if (r_rd_beat) begin
        r_resp_data <= mem_data_out;
      end
      if (w_take && !w_bad) begin
        r_addr <= req_addr;
        r_rw   <= req_rw;
        r_size <= req_size;
      end else if (w_accept) begin
        r_addr <= r_addr + ADDR_W'(4);
      end
    end
  end

  assign req_ready       = w_ready;
  assign req_err         = r_err;
  assign wdata_pop       = r_pop;
  assign resp_valid      = r_resp_valid;
  assign resp_last       = r_resp_last;
  assign resp_data       = r_resp_data;
  assign mem_enable      = w_enable;
  assign mem_address     = r_addr;
  assign mem_rw          = r_rw;
  assign mem_access_size = r_size;
  assign mem_data_in     = (w_enable && (r_rw == RW_WRITE)) ? wdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_burst_initiator.sv
`default_nettype none
// ============================================================================
// tb_mem_burst_initiator : directed + randomized bench with a behavioural memory
// Rev 1.0
// ============================================================================
module tb_mem_burst_initiator;

  localparam logic [31:0] START     = 32'h8002_0000;
  localparam logic [31:0] MEM_BYTES = 32'h0010_0000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_rw = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] wdata = 32'd0;
  logic        wdata_pop;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_last;
  logic        req_err;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic [1:0]  mem_access_size;
  logic        mem_rw;
  logic        mem_enable;
  logic        mem_busy = 1'b0;
  logic [31:0] mem_data_out = 32'd0;

  mem_burst_initiator dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_rw          (req_rw),
    .req_addr        (req_addr),
    .req_size        (req_size),
    .wdata           (wdata),
    .wdata_pop       (wdata_pop),
    .resp_valid      (resp_valid),
    .resp_data       (resp_data),
    .resp_last       (resp_last),
    .req_err         (req_err),
    .mem_address     (mem_address),
    .mem_data_in     (mem_data_in),
    .mem_access_size (mem_access_size),
    .mem_rw          (mem_rw),
    .mem_enable      (mem_enable),
    .mem_busy        (mem_busy),
    .mem_data_out    (mem_data_out)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- behavioural byte-addressed memory (big-endian words)
  logic [7:0]  mem_bytes [logic [31:0]];
  logic [31:0] wr_words[$];
  int          wr_idx = 0;
  int          acc_n = 0;
  int          stall_beat = -1;
  int          stall_left = 0;
  int          busy_pct = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    for (int b = 0; b < 4; b++)
      if (mem_bytes.exists(a + 32'(b))) w[31-8*b -: 8] = mem_bytes[a + 32'(b)];
    return w;
  endfunction

  task automatic store_word(input logic [31:0] a, input logic [31:0] w);
    for (int b = 0; b < 4; b++) mem_bytes[a + 32'(b)] = w[31-8*b -: 8];
  endtask

  always begin
    @(posedge clock);
    if (mem_enable && !mem_busy) begin
      acc_n++;
      if (mem_rw) mem_data_out <= mem_word(mem_address);
      else        store_word(mem_address, mem_data_in);
    end else begin
      mem_data_out <= $urandom;
    end
  end

  // client write-data advance and memory busy generation
  always begin
    @(posedge clock);
    #1;
    if (wdata_pop) begin
      wr_idx++;
      wdata = (wr_idx < wr_words.size()) ? wr_words[wr_idx] : $urandom;
    end
    if (mem_enable && stall_left > 0 && acc_n == stall_beat - 1) begin
      mem_busy = 1'b1;
      stall_left--;
    end else begin
      mem_busy = mem_enable && ($urandom_range(0, 99) < busy_pct);
    end
  end

  // ---------------- checking helpers
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [31:0] acc_addr_q[$];
  logic [2:0]  acc_ctl_q[$];
  int          acc_cyc_q[$];
  logic [31:0] resp_q[$];
  logic        resp_last_q[$];
  int          resp_cyc_q[$];
  int          pop_n = 0, err_n = 0, en_n = 0, first_en_cyc = -1;
  logic        prev_stall = 1'b0, prev_rw = 1'b0;
  logic [31:0] prev_addr = 32'd0, prev_data = 32'd0;

  always begin
    @(negedge clock);
    if (resp_valid) begin
      resp_q.push_back(resp_data);
      resp_last_q.push_back(resp_last);
      resp_cyc_q.push_back(cyc);
    end
    if (wdata_pop) pop_n++;
    if (req_err)   err_n++;
    if (mem_enable) begin
      en_n++;
      if (first_en_cyc < 0) first_en_cyc = cyc;
      if (!mem_busy) begin
        acc_addr_q.push_back(mem_address);
        acc_ctl_q.push_back({mem_rw, mem_access_size});
        acc_cyc_q.push_back(cyc);
      end
    end
    if (prev_stall && reset_n) begin
      chk("hold_addr", mem_address, prev_addr);
      chk("hold_wdata", mem_data_in, prev_data);
      chk("hold_rw", 32'(mem_rw), 32'(prev_rw));
    end
    prev_stall = mem_enable && mem_busy && reset_n;
    prev_addr  = mem_address;
    prev_data  = mem_data_in;
    prev_rw    = mem_rw;
  end

  // ---------------- reference model of the request rules
  function automatic int nwords(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 4 : (s == 2'd2) ? 8 : 16;
  endfunction

  function automatic bit legal(input logic [31:0] a, input logic [1:0] s);
    longint lo, hi;
    lo = longint'(a);
    hi = lo + 4 * nwords(s) - 1;
    return (a[1:0] == 2'b00) && (lo >= longint'(START))
           && (hi <= longint'(START) + longint'(MEM_BYTES) - 1);
  endfunction

  task automatic clear_logs();
    acc_addr_q.delete(); acc_ctl_q.delete(); acc_cyc_q.delete();
    resp_q.delete(); resp_last_q.delete(); resp_cyc_q.delete();
    pop_n = 0; err_n = 0; en_n = 0; first_en_cyc = -1; acc_n = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_req(input logic rw, input logic [31:0] addr, input logic [1:0] size,
                           output int t_c);
    int k;
    k = 0;
    while (!req_ready && k < 200) begin tick(); k++; end
    chk("idle_wait", 32'(k < 200), 32'd1);
    req_valid = 1'b1; req_rw = rw; req_addr = addr; req_size = size;
    tick();
    t_c = cyc;
    req_valid = 1'b0; req_rw = 1'($urandom); req_addr = $urandom; req_size = 2'($urandom);
  endtask

  task automatic run_req(input logic rw, input logic [31:0] addr, input logic [1:0] size,
                         input string tag, input bit timing);
    int n, t_c, k;
    bit ok, done;
    logic [31:0] exp_rd[$];
    n  = nwords(size);
    ok = legal(addr, size);
    clear_logs();
    wr_words.delete();
    for (int i = 0; i < n; i++) wr_words.push_back($urandom);
    wr_idx = 0;
    wdata  = wr_words[0];
    for (int i = 0; i < n; i++) exp_rd.push_back(mem_word(addr + 32'(4 * i)));
    start_req(rw, addr, size, t_c);
    done = 1'b0;
    k = 0;
    while (!done && k < 400) begin
      tick(); k++;
      if (!ok)     done = (err_n > 0) && (k >= 4);
      else if (rw) done = (resp_q.size() >= n);
      else         done = (pop_n >= n);
    end
    repeat (3) tick();
    chk($sformatf("%s_done", tag), 32'(done), 32'd1);
    if (!ok) begin
      chk($sformatf("%s_err", tag), err_n, 1);
      chk($sformatf("%s_noenable", tag), en_n, 0);
    end else begin
      chk($sformatf("%s_noerr", tag), err_n, 0);
      chk($sformatf("%s_beats", tag), acc_addr_q.size(), n);
      for (int i = 0; i < n && i < acc_addr_q.size(); i++) begin
        chk($sformatf("%s_addr%0d", tag, i), acc_addr_q[i], addr + 32'(4 * i));
        chk($sformatf("%s_ctl%0d", tag, i), 32'(acc_ctl_q[i]), 32'({rw, size}));
      end
      if (rw) begin
        chk($sformatf("%s_nresp", tag), resp_q.size(), n);
        for (int i = 0; i < n && i < resp_q.size(); i++) begin
          chk($sformatf("%s_data%0d", tag, i), resp_q[i], exp_rd[i]);
          chk($sformatf("%s_last%0d", tag, i), 32'(resp_last_q[i]), 32'(i == n - 1));
        end
      end else begin
        chk($sformatf("%s_pops", tag), pop_n, n);
        for (int i = 0; i < n; i++)
          chk($sformatf("%s_mem%0d", tag, i), mem_word(addr + 32'(4 * i)), wr_words[i]);
      end
      if (timing) begin
        chk($sformatf("%s_first_en", tag), first_en_cyc, t_c + 1 - 1);
        chk($sformatf("%s_en_cycles", tag), en_n, n);
        if (rw && resp_q.size() > 0) begin
          chk($sformatf("%s_first_resp", tag), resp_cyc_q[0], t_c + 3 - 1);
          for (int i = 1; i < resp_q.size(); i++)
            chk($sformatf("%s_b2b%0d", tag, i), resp_cyc_q[i] - resp_cyc_q[i-1], 1);
        end
      end
    end
    chk($sformatf("%s_ready", tag), 32'(req_ready), 32'd1);
  endtask

  // ---------------- stimulus
  initial begin
    int k, n0, en0;
    logic [31:0] a;
    logic [31:0] exp6[$];

    // asynchronous reset, checked before any clock edge
    #2 reset_n = 1'b0;
    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_enable", 32'(mem_enable), 32'd0);
    chk("rst_flags", 32'({resp_valid, resp_last, wdata_pop, req_err, mem_rw}), 32'd0);
    chk("rst_addr", mem_address, 32'd0);
    chk("rst_rdata", resp_data, 32'd0);
    chk("rst_size", 32'(mem_access_size), 32'd0);
    chk("rst_wdata", mem_data_in, 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock) reset_n = 1'b1;
    tick();

    // single read with fixed memory word
    store_word(START, 32'hDEAD_BEEF);
    run_req(1'b1, START, 2'b00, "single_rd", 1'b1);
    chk("single_rd_word", (resp_q.size() > 0) ? resp_q[0] : 32'hX, 32'hDEAD_BEEF);

    // 4-word read, beat 2 stalled for two cycles
    stall_beat = 2; stall_left = 2;
    run_req(1'b1, START + 32'h10, 2'b01, "stall_rd", 1'b0);
    chk("stall_rd_hold", (acc_cyc_q.size() > 1) ? 32'(acc_cyc_q[1] - acc_cyc_q[0]) : 32'hX, 32'd3);
    stall_beat = -1; stall_left = 0;

    // 16-word write
    run_req(1'b0, START + 32'h40, 2'b11, "wr16", 1'b1);
    chk("wr16_msb_byte", 32'(mem_bytes[START + 32'h40]), 32'(wr_words[0][31:24]));

    // rejects and the boundary around the top of memory
    run_req(1'b1, 32'h8002_0002, 2'b00, "rej_align", 1'b0);
    run_req(1'b0, 32'h8001_FFFC, 2'b10, "rej_low", 1'b0);
    run_req(1'b1, 32'h8011_FFF0, 2'b11, "rej_top", 1'b0);
    run_req(1'b1, 32'h800F_FFF0, 2'b11, "mid_16", 1'b0);
    run_req(1'b0, 32'h8011_FFC0, 2'b11, "top_fit", 1'b1);

    // reset while beat 5 of an 8-word read is on the port
    clear_logs();
    start_req(1'b1, START + 32'h100, 2'b10, k);
    k = 0;
    while (acc_n < 4 && k < 100) begin tick(); k++; end
    chk("rst_mid_reach", 32'(acc_n), 32'd4);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_enable", 32'(mem_enable), 32'd0);
    chk("rst_mid_ready", 32'(req_ready), 32'd1);
    chk("rst_mid_resp", 32'(resp_valid), 32'd0);
    n0 = resp_q.size(); en0 = en_n;
    @(negedge clock);
    #1 reset_n = 1'b1;
    repeat (10) tick();
    chk("rst_mid_noresp", resp_q.size(), n0);
    chk("rst_mid_noen", en_n, en0);
    run_req(1'b1, START + 32'h20, 2'b00, "post_rst", 1'b1);

    // request held valid across an 8-word read
    clear_logs();
    a = START + 32'h200;
    for (int i = 0; i < 8; i++) exp6.push_back(mem_word(a + 32'(4 * i)));
    req_valid = 1'b1; req_rw = 1'b1; req_addr = a; req_size = 2'b10;
    k = 0;
    while (!(resp_valid && resp_last) && k < 200) begin tick(); k++; end
    chk("hold_first_done", 32'(k < 200), 32'd1);
    tick();
    req_valid = 1'b0;
    k = 0;
    while (resp_q.size() < 16 && k < 200) begin tick(); k++; end
    repeat (3) tick();
    chk("hold_nresp", resp_q.size(), 16);
    chk("hold_beats", acc_addr_q.size(), 16);
    for (int i = 0; i < 16 && i < resp_q.size(); i++) begin
      chk($sformatf("hold_data%0d", i), resp_q[i], exp6[i % 8]);
      chk($sformatf("hold_last%0d", i), 32'(resp_last_q[i]), 32'((i % 8) == 7));
    end
    if (acc_cyc_q.size() > 8 && resp_cyc_q.size() > 7)
      chk("hold_second_take", acc_cyc_q[8], resp_cyc_q[7] + 1);
    else
      chk("hold_second_take", 32'd0, 32'd1);

    // randomized requests, legal and illegal, with random busy
    for (int it = 0; it < 14; it++) begin
      int sel;
      sel = $urandom_range(0, 9);
      case (sel)
        0:       a = START + 32'(4 * $urandom_range(0, 1000)) + 32'($urandom_range(1, 3));
        1:       a = START - 32'(4 * $urandom_range(1, 64));
        2:       a = START + MEM_BYTES - 32'(4 * $urandom_range(1, 20));
        default: a = START + 32'(4 * $urandom_range(0, 262144 - 16));
      endcase
      busy_pct = $urandom_range(0, 40);
      run_req(1'($urandom), a, 2'($urandom), $sformatf("rand%0d", it), 1'b0);
      busy_pct = 0;
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
